bt_uart_rx: RTL and testbench

- Receive side of the Bluetooth serial link; consumes the 9600-baud serial stream from the Bluetooth module on the same system clock the baud divider uses.
- Self-timed 8N1 receiver: 2-flop synchroniser, start-bit qualification, mid-bit sampling, stop-bit check.
- Received bytes are buffered in a small show-ahead FIFO read by the command decoder.
- Error flags are sticky and cleared by software.

---
 rtl/bt_uart_rx.sv | 177 +++++++++++++++++
 tb/tb_bt_uart_rx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bt_uart_rx.sv
// Bluetooth link receiver: 2-flop synchroniser, self-timed 8N1 deserialiser, show-ahead byte FIFO, sticky errors.
// Define BT_RX_PARITY_EN to receive 8E1 frames and add the parity_err output.
module bt_uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_AW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               full,
  output logic [FIFO_AW:0]   level,
  output logic               frame_err,
  output logic               overflow,
`ifdef BT_RX_PARITY_EN
  output logic               parity_err,
`endif
  input  logic               clr_err,
  output logic [2:0]         fsm_state
);

  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          par_bad;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_cnt;
  logic [FIFO_AW:0] rd_cnt;

  logic stop_hit;
  logic push_req;
  logic frame_set;
  logic parity_set;
  logic pop;
  logic push_ok;
  logic ovf_set;

  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // cnt free-runs modulo CLKS_PER_BIT; every state change forces it back to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bad <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          par_bad <= 1'b0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            idx <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            shift[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef BT_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef BT_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            par_bad <= ^shift ^ rx_s;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) state <= rx_s ? S_IDLE : S_WAIT_IDLE;
        end
        S_WAIT_IDLE: begin
          cnt <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign stop_hit   = (state == S_STOP) && (cnt == CNT_LAST);
  assign push_req   = stop_hit && rx_s && !par_bad;
  assign frame_set  = stop_hit && !rx_s;
  assign parity_set = (state == S_PARITY) && (cnt == CNT_LAST) && (^shift ^ rx_s);

  // A full FIFO can still take a byte when the head is popped in the same cycle.
  assign level   = wr_cnt - rd_cnt;
  assign empty   = (level == '0);
  assign full    = (level == (FIFO_AW + 1)'(DEPTH));
  assign pop     = rd_en && !empty;
  assign push_ok = push_req && (!full || pop);
  assign ovf_set = push_req && full && !rd_en;
  assign rd_data = mem[rd_cnt[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_cnt[FIFO_AW-1:0]] <= shift;
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (pop) rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frame_set | (frame_err & ~clr_err);
      overflow  <= ovf_set   | (overflow  & ~clr_err);
    end
  end

`ifdef BT_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= parity_set | (parity_err & ~clr_err);
  end
`else
  logic parity_unused;
  assign parity_unused = parity_set;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// Directed bench for bt_uart_rx: queue model of the FIFO/flags scheduled from frame timing, checked every cycle.
module tb_bt_uart_rx;
  localparam int CPB   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          frame_err;
  logic          overflow;
  logic [2:0]    fsm_state;
`ifdef BT_RX_PARITY_EN
  logic          parity_err;
`endif

  bt_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .level(level),
    .frame_err(frame_err), .overflow(overflow),
`ifdef BT_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .clr_err(clr_err), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: byte queue plus sticky flags; frame outcomes land on the edge that samples the stop bit.
  logic [7:0] exp_q[$];
  logic       m_fe = 1'b0, m_ov = 1'b0, m_pe = 1'b0;
  int         edge_cnt = 0;
  logic       sched_valid = 1'b0;
  int         sched_edge = 0;
  logic [7:0] sched_byte = '0;
  logic       sched_stop = 1'b1;
  logic       sched_pbad = 1'b0;
  logic       par_flip = 1'b0;

  always @(posedge clk) begin
    logic do_pop, push, fe_set, ov_set, pe_set;
    edge_cnt++;
    do_pop = 0; push = 0; fe_set = 0; ov_set = 0; pe_set = 0;
    if (!rst_n) begin
      exp_q.delete();
      m_fe = 0; m_ov = 0; m_pe = 0;
      sched_valid = 0;
    end else begin
      do_pop = rd_en && (exp_q.size() > 0);
      if (sched_valid && sched_pbad && edge_cnt == sched_edge - CPB) pe_set = 1;
      if (sched_valid && edge_cnt == sched_edge) begin
        sched_valid = 0;
        if (!sched_stop) fe_set = 1;
        else if (!sched_pbad) push = 1;
      end
      if (push && exp_q.size() == DEPTH && !do_pop) ov_set = 1;
      if (clr_err) begin m_fe = 0; m_ov = 0; m_pe = 0; end
      if (do_pop) void'(exp_q.pop_front());
      if (push && !ov_set) exp_q.push_back(sched_byte);
      if (fe_set) m_fe = 1;
      if (ov_set) m_ov = 1;
      if (pe_set) m_pe = 1;
    end
  end

  always @(negedge clk) begin
    if (edge_cnt > 0) begin
      chk("cyc_empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("cyc_full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("cyc_level", 32'(level), 32'(exp_q.size()));
      if (exp_q.size() > 0) chk("cyc_rd_data", 32'(rd_data), 32'(exp_q[0]));
      chk("cyc_frame_err", 32'(frame_err), 32'(m_fe));
      chk("cyc_overflow", 32'(overflow), 32'(m_ov));
`ifdef BT_RX_PARITY_EN
      chk("cyc_parity_err", 32'(parity_err), 32'(m_pe));
`endif
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; drives one frame, optionally popping in the stop-sample cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pop_at_stop);
    logic [10:0] bits;
    int nb;
`ifdef BT_RX_PARITY_EN
    bits = {stop, ^d ^ par_flip, d, 1'b0};
    nb = 11;
`else
    bits = {1'b0, stop, d, 1'b0};
    nb = 10;
`endif
    sched_byte  = d;
    sched_stop  = stop;
    sched_pbad  = par_flip;
    sched_edge  = edge_cnt + 11 + CPB * (nb - 1);
    sched_valid = 1;
    for (int b = 0; b < nb; b++) begin
      rx = bits[b];
      for (int k = 0; k < CPB; k++) begin
        rd_en = pop_at_stop && (edge_cnt == sched_edge - 1);
        @(negedge clk);
      end
    end
    rd_en = 0;
  endtask

  task automatic pop_byte(input logic [7:0] exp, input string name);
    chk(name, 32'(rd_data), 32'(exp));
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
  endtask

  task automatic pulse_clr();
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  initial begin
    idle(3);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_flags", 32'({frame_err, overflow}), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    rst_n = 1;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3);
    chk("a5_data", 32'(rd_data), 32'hA5);
    chk("a5_level", 32'(level), 32'd1);
    chk("a5_flags", 32'({frame_err, overflow}), 32'd0);
    pop_byte(8'hA5, "a5_pop");

    rx = 0;
    idle(5);
    rx = 1;
    idle(20);
    chk("glitch_state", 32'(fsm_state), 32'd0);
    chk("glitch_empty", 32'(empty), 32'd1);
    chk("glitch_frame_err", 32'(frame_err), 32'd0);

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    rx = 1;
    idle(5);
    chk("brk_frame_err", 32'(frame_err), 32'd1);
    chk("brk_empty", 32'(empty), 32'd1);
    send_frame(8'h11, 1'b1, 1'b0);
    idle(3);
    pop_byte(8'h11, "after_brk_pop");
    pulse_clr();
    chk("brk_cleared", 32'(frame_err), 32'd0);

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      idle(3);
    end
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) pop_byte(8'(i), "ovf_pop");
    chk("ovf_drained", 32'(empty), 32'd1);
    pulse_clr();
    chk("ovf_cleared", 32'(overflow), 32'd0);

    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      idle(3);
    end
    chk("pp_full", 32'(full), 32'd1);
    send_frame(8'h05, 1'b1, 1'b1);
    idle(3);
    chk("pp_overflow", 32'(overflow), 32'd0);
    chk("pp_level", 32'(level), 32'd4);
    for (int i = 2; i <= 5; i++) pop_byte(8'(i), "pp_pop");
    chk("pp_drained", 32'(empty), 32'd1);

    send_frame(8'h11, 1'b1, 1'b0);
    idle(3);
    rx = 0;
    idle(30);
    rst_n = 0;
    idle(2);
    rst_n = 1;
    rx = 1;
    idle(3);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(3);
    pop_byte(8'h5A, "midrst_recover");

`ifdef BT_RX_PARITY_EN
    par_flip = 1;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(3);
    chk("par_err_set", 32'(parity_err), 32'd1);
    chk("par_not_pushed", 32'(empty), 32'd1);
    par_flip = 0;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(3);
    pop_byte(8'h07, "par_good_pop");
    chk("par_err_sticky", 32'(parity_err), 32'd1);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
